// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcodes, ALU codes, FSM states, instruction classes and trap codes
package multicycle_control_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] TRAP_NONE = 2'd0;
    localparam logic [1:0] TRAP_ILL  = 2'd1;
    localparam logic [1:0] TRAP_TMO  = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_ADD  = 4'd0,
        C_SUB  = 4'd1,
        C_AND  = 4'd2,
        C_OR   = 4'd3,
        C_ADDI = 4'd4,
        C_LD   = 4'd5,
        C_SD   = 4'd6,
        C_BEQ  = 4'd7,
        C_ILL  = 4'd8
    } iclass_t;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: shared instruction/data memory request port
interface multicycle_control_if;

    logic mem_req;
    logic mem_is_fetch;
    logic mem_read;
    logic mem_write;
    logic mem_ready;

    modport master (output mem_req, mem_is_fetch, mem_read, mem_write, input mem_ready);
    modport slave  (input mem_req, mem_is_fetch, mem_read, mem_write, output mem_ready);

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder: classifies an instruction and derives its ALU op and operand select
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output iclass_t    cls,
    output logic [3:0] alu_control_signal,
    output logic       alu_src,
    output logic       illegal
);

    always_comb begin
        cls = C_ILL;
        case (opcode)
            OP_R:    cls = funct3 == 3'b000 ? (funct7b5 ? C_SUB : C_ADD) :
                           funct3 == 3'b111 ? C_AND :
                           funct3 == 3'b110 ? C_OR : C_ILL;
            OP_I:    cls = funct3 == 3'b000 ? C_ADDI : C_ILL;
            OP_LD:   cls = funct3 == 3'b011 ? C_LD : C_ILL;
            OP_SD:   cls = funct3 == 3'b011 ? C_SD : C_ILL;
            OP_BR:   cls = funct3 == 3'b000 ? C_BEQ : C_ILL;
            default: cls = C_ILL;
        endcase
    end

    assign alu_control_signal = (cls == C_SUB || cls == C_BEQ) ? ALU_SUB :
                                cls == C_AND ? ALU_AND :
                                cls == C_OR  ? ALU_OR  : ALU_ADD;
    assign alu_src = cls == C_ADDI || cls == C_LD || cls == C_SD;
    assign illegal = cls == C_ILL;

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout trap and retire counter
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_en,
    input  logic [31:0]           instr,
    input  logic                  alu_zero,
    multicycle_control_if.master  mem,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  Branch,
    output logic                  alu_src,
    output logic [3:0]            alu_control_signal,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic [CNT_W-1:0]      retired,
    output logic                  halted,
    output logic [1:0]            trap_cause
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state, state_n, boundary;
    iclass_t           d_cls, cls_q;
    logic [3:0]        d_alu, alu_q;
    logic              d_src, src_q, illegal;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        trap_n;
    logic              mem_phase, timeout, alu_live;
    logic              unused_instr;

    alu_decoder u_dec (
        .opcode             (instr[6:0]),
        .funct3             (instr[14:12]),
        .funct7b5           (instr[30]),
        .cls                (d_cls),
        .alu_control_signal (d_alu),
        .alu_src            (d_src),
        .illegal            (illegal)
    );

    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
    assign boundary     = run_en ? FETCH : IDLE;
    assign mem_phase    = state == FETCH || state == MEM;
    // The MEM_TIMEOUT-th waiting cycle is the last one allowed; a late mem_ready there still wins.
    assign timeout      = mem_phase && !mem.mem_ready && wait_cnt == WAIT_W'(MEM_TIMEOUT - 1);
    assign alu_live     = !reset && (state == EXEC || state == MEM || state == WB);
    assign alu_control_signal = alu_live ? alu_q : 4'b0000;
    assign alu_src      = alu_live && src_q;
    assign halted       = state == HALT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            retired    <= '0;
            trap_cause <= TRAP_NONE;
            cls_q      <= C_ADD;
            alu_q      <= 4'b0000;
            src_q      <= 1'b0;
        end else begin
            state      <= state_n;
            trap_cause <= trap_n;
            wait_cnt   <= (mem_phase && !mem.mem_ready) ? wait_cnt + 1'b1 : '0;
            if (pc_write)
                retired <= retired + 1'b1;
            if (state == DECODE) begin
                cls_q <= d_cls;
                alu_q <= d_alu;
                src_q <= d_src;
            end
        end
    end

    always_comb begin
        state_n          = state;
        trap_n           = trap_cause;
        mem.mem_req      = 1'b0;
        mem.mem_is_fetch = 1'b0;
        mem.mem_read     = 1'b0;
        mem.mem_write    = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        Branch           = 1'b0;
        reg_write        = 1'b0;
        mem_to_reg       = 1'b0;
        case (state)
            IDLE: state_n = run_en ? FETCH : IDLE;
            FETCH: begin
                mem.mem_req      = 1'b1;
                mem.mem_is_fetch = 1'b1;
                ir_write         = mem.mem_ready;
                state_n          = mem.mem_ready ? DECODE : timeout ? HALT : FETCH;
                trap_n           = timeout ? TRAP_TMO : trap_cause;
            end
            DECODE: begin
                state_n = illegal ? HALT : EXEC;
                trap_n  = illegal ? TRAP_ILL : trap_cause;
            end
            EXEC: begin
                pc_write = cls_q == C_BEQ;
                Branch   = cls_q == C_BEQ && alu_zero;
                state_n  = cls_q == C_BEQ ? boundary :
                           (cls_q == C_LD || cls_q == C_SD) ? MEM : WB;
            end
            MEM: begin
                mem.mem_req   = 1'b1;
                mem.mem_read  = cls_q == C_LD;
                mem.mem_write = cls_q == C_SD;
                pc_write      = mem.mem_ready && cls_q == C_SD;
                state_n       = mem.mem_ready ? (cls_q == C_LD ? WB : boundary) :
                                timeout ? HALT : MEM;
                trap_n        = timeout ? TRAP_TMO : trap_cause;
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = cls_q == C_LD;
                pc_write   = 1'b1;
                state_n    = boundary;
            end
            default: state_n = HALT;
        endcase
        // Reset wins over any in-flight request or write in the cycle it is asserted.
        if (reset) begin
            mem.mem_req      = 1'b0;
            mem.mem_is_fetch = 1'b0;
            mem.mem_read     = 1'b0;
            mem.mem_write    = 1'b0;
            ir_write         = 1'b0;
            pc_write         = 1'b0;
            Branch           = 1'b0;
            reg_write        = 1'b0;
            mem_to_reg       = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM that sequences the execute datapath (ALU, PC+4 adder, branch-target mux) and a single shared instruction/data memory port.
- Each instruction moves through FETCH, DECODE, EXEC, optional MEM and optional WB.
- The block drives ALU op, operand select, Branch select, PC/IR/register-file write enables and memory requests.
- It counts retired instructions and halts with a trap cause on an illegal opcode or a memory timeout.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).
- MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready in FETCH or MEM before trapping; must be >= 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run_en  in  1  start/continue; sampled in IDLE and at instruction boundaries.
- instr  in  32  current IR contents; valid from the cycle after the ir_write pulse.
- alu_zero  in  1  ALU result==0 flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request active.
- mem_is_fetch  out  1  1 = instruction fetch, 0 = data access.
- mem_read  out  1  data load.
- mem_write  out  1  data store.
- ir_write  out  1  latch instr into the IR.
- pc_write  out  1  load next_PC into the PC.
- Branch  out  1  next_PC mux select: 1 = branch target, 0 = PC+4.
- alu_src  out  1  ALU operand b: 0 = rd2, 1 = immediate.
- alu_control_signal  out  4  ALU op code.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  write-back source: 1 = load data, 0 = ALU output.
- retired  out  CNT_W  retired-instruction count.
- halted  out  1  FSM is in HALT.
- trap_cause  out  2  0 = none, 1 = illegal instruction, 2 = memory timeout.

Behaviour:
- Reset:
  - state=IDLE; every output 0, including retired, trap_cause and halted.
  - Outputs are a combinational function of the registered state, the registered instruction class and current inputs.
  - Reset asserted in any state, including mid-MEM or HALT, returns to IDLE next cycle; no write enables are asserted that cycle.
- IDLE: all outputs 0. run_en=1 -> FETCH.
- FETCH:
  - mem_req=1, mem_is_fetch=1.
  - mem_ready=1 -> ir_write=1 this cycle, go to DECODE.
  - Otherwise stay and increment the wait counter.
  - Wait counter reaching MEM_TIMEOUT without mem_ready -> HALT, trap_cause=2.
- DECODE: register the instruction class from instr[6:0], instr[14:12] and instr[30]:
  - 0110011 R-type: f3=000,f7b5=0 ADD; f3=000,f7b5=1 SUB; f3=111 AND; f3=110 OR.
  - 0010011 f3=000 ADDI.
  - 0000011 f3=011 LD.
  - 0100011 f3=011 SD.
  - 1100011 f3=000 BEQ.
  - Anything else is illegal -> HALT, trap_cause=1.
  - Otherwise -> EXEC.
- EXEC:
  - Drive alu_control_signal: ADD=4'b0010, SUB=4'b0110, AND=4'b0000, OR=4'b0001. LD, SD and ADDI use ADD; BEQ uses SUB.
  - alu_src=1 for ADDI/LD/SD, 0 otherwise.
  - R/ADDI -> WB. LD/SD -> MEM.
  - BEQ: pc_write=1, Branch=alu_zero, retire, then boundary.
- alu_control_signal and alu_src hold their EXEC value through MEM and WB of the same instruction; they are 0 in IDLE, FETCH, DECODE and HALT.
- MEM:
  - mem_req=1, mem_is_fetch=0; mem_read=1 for LD, mem_write=1 for SD.
  - Waits on mem_ready with the same timeout rule as FETCH.
  - On mem_ready: LD -> WB. SD -> pc_write=1, Branch=0, retire, then boundary.
- WB: reg_write=1, mem_to_reg=(class==LD), pc_write=1, Branch=0, retire, then boundary.
- Boundary: run_en=1 -> FETCH, else -> IDLE. run_en is ignored mid-instruction.
- Retire: retired+1 in the same cycle as pc_write (a one-cycle pulse); wraps from all-ones to 0.
- Wait counter:
  - Cleared on entry to FETCH or MEM and on every mem_ready.
  - A mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT counts as success, not timeout.
- HALT:
  - All control outputs 0; halted=1; trap_cause held.
  - Leaves only on reset.
- mem_ready outside FETCH/MEM is ignored.
- pc_write, ir_write and reg_write are single-cycle pulses per instruction.

Decomposition:
- Shared include ctrl_defs.v holds:
  - opcode constants;
  - ALU code constants;
  - 3-bit state encodings IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6;
  - instruction-class encodings;
  - trap codes.
- One combinational sub-module, alu_decoder: takes opcode, funct3 and funct7b5; produces class, alu_control_signal, alu_src and illegal.
- multicycle_control holds the FSM, wait counter and retire counter.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready on the 1st FETCH cycle, run_en=1 -> states FETCH,DECODE,EXEC,WB over 4 cycles; alu_control_signal=0010 in EXEC/WB; reg_write=1 and pc_write=1 only in WB; retired 0->1.
- sub x3,x1,x2 (0x402081B3) then BEQ (f3=000) with alu_zero=1 -> SUB uses 0110. BEQ asserts Branch=1 and pc_write=1 in EXEC with no WB; BEQ with alu_zero=0 asserts Branch=0.
- ld x3,0(x1) (0x0000B183), mem_ready delayed 3 cycles in MEM:
  - mem_read=1 and alu_control_signal=0010 for 4 MEM cycles;
  - then WB with mem_to_reg=1;
  - an SD sequence shows mem_write=1, pc_write in the MEM exit cycle, and no reg_write.
- Illegal opcode 0x0000007F -> HALT after DECODE; halted=1, trap_cause=1, no further mem_req, retired unchanged; reset -> IDLE with all outputs 0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> HALT, trap_cause=2. Repeat with mem_ready arriving exactly on the 4th wait cycle -> no trap.
- run_en dropped during EXEC of an ADD -> instruction completes WB, then IDLE. With CNT_W=2 and 4 retired instructions, retired wraps 3->0.
